// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode map and small helpers
// used by the fetch/execute control path.
package cpu_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_FETCH  = 3'd1;
  localparam seq_state_t ST_DECODE = 3'd2;
  localparam seq_state_t ST_START  = 3'd3;
  localparam seq_state_t ST_EXEC   = 3'd4;
  localparam seq_state_t ST_HALT   = 3'd5;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OPC_ADD  = 3'b000;
  localparam opcode_t OPC_SUB  = 3'b001;
  localparam opcode_t OPC_AND  = 3'b010;
  localparam opcode_t OPC_OR   = 3'b011;
  localparam opcode_t OPC_LD   = 3'b100;
  localparam opcode_t OPC_ST   = 3'b101;
  localparam opcode_t OPC_JMP  = 3'b110;
  localparam opcode_t OPC_HALT = 3'b111;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Sequencer-facing bundle: memory read handshake, IR capture and the
// execute-controller start/wait pair, plus status outputs.
interface fetch_sequencer_if #(
  parameter int PC_W = 9
);
  logic            run;
  logic            mem_ready;
  logic            exec_wait;
  logic [2:0]      ir_opcode;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic            load_ir;
  logic            exec_start;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [15:0]     retired_cnt;

  modport master (
    input  run, mem_ready, exec_wait, ir_opcode,
    output mem_rd, mem_addr, load_ir, exec_start, pc, halted, retired_cnt
  );

  modport slave (
    output run, mem_ready, exec_wait, ir_opcode,
    input  mem_rd, mem_addr, load_ir, exec_start, pc, halted, retired_cnt
  );
endinterface

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter register: loads its reset value, increments by one on
// request and wraps naturally at 2^W.
module pc_counter #(
  parameter int            W         = 9,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] pc
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // PC register with wrap-around increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VAL;
    end else if (inc) begin
      pc <= pc + ONE;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: fetches from memory, loads IR, issues to the execute
// controller with a one-cycle start pulse and counts retired instructions.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  seq_state_t      state_r;
  seq_state_t      state_nxt_s;
  logic            pc_inc_s;
  logic            retire_s;
  logic            exec_first_r;
  logic            mem_rd_r;
  logic            exec_start_r;
  logic            halted_r;
  logic [15:0]     retired_cnt_r;
  logic [PC_W-1:0] pc_s;

  pc_counter #(
    .W         (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc_s),
    .pc    (pc_s)
  );

  // Next-state logic; the first EXEC cycle never completes because the
  // execute controller only drops its wait flag on the START edge.
  always_comb begin
    state_nxt_s = state_r;
    pc_inc_s    = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.run) state_nxt_s = ST_FETCH;
        else         state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.mem_ready) state_nxt_s = ST_DECODE;
        else               state_nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (bus.ir_opcode == OPC_HALT) begin
          state_nxt_s = ST_HALT;
        end else if (bus.exec_wait) begin
          pc_inc_s    = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_DECODE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (!exec_first_r && bus.exec_wait) begin
          retire_s    = 1'b1;
          state_nxt_s = bus.run ? ST_FETCH : ST_IDLE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, registered Moore outputs and saturating retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      exec_first_r  <= 1'b0;
      mem_rd_r      <= 1'b0;
      exec_start_r  <= 1'b0;
      halted_r      <= 1'b0;
      retired_cnt_r <= 16'd0;
    end else begin
      state_r       <= state_nxt_s;
      exec_first_r  <= (state_r == ST_START);
      mem_rd_r      <= (state_nxt_s == ST_FETCH);
      exec_start_r  <= (state_nxt_s == ST_START);
      halted_r      <= (state_nxt_s == ST_HALT);
      if (retire_s) begin
        retired_cnt_r <= sat_inc16(retired_cnt_r);
      end
    end
  end

  // load_ir follows mem_ready combinationally while the read is outstanding
  assign bus.mem_rd      = mem_rd_r;
  assign bus.mem_addr    = pc_s;
  assign bus.load_ir     = mem_rd_r & bus.mem_ready;
  assign bus.exec_start  = exec_start_r;
  assign bus.pc          = pc_s;
  assign bus.halted      = halted_r;
  assign bus.retired_cnt = retired_cnt_r;
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Top-level instruction sequencer for the multi-cycle RISC CPU. Owns the program counter, fetches each instruction from memory over a ready handshake, loads the instruction register, then hands the instruction to the execute controller via its start/wait handshake (`s`/`w`). Stops permanently on a HALT opcode until reset. Sits between instruction memory and the execute controller.

## Interface
Parameters:
- `PC_W`, 9, program counter / memory address width
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `run`  in  1  level; 1 = keep fetching, 0 = stop in IDLE after current instruction
- `mem_ready`  in  1  memory read data valid this cycle
- `exec_wait`  in  1  execute controller idle (its `w`)
- `ir_opcode`  in  3  opcode field of the current IR contents
- `mem_rd`  out  1  memory read request
- `mem_addr`  out  PC_W  read address, equals `pc` whenever `mem_rd`=1
- `load_ir`  out  1  IR capture enable
- `exec_start`  out  1  drives execute controller `s`
- `pc`  out  PC_W  program counter
- `halted`  out  1  HALT state reached
- `retired_cnt`  out  16  instructions completed, saturating

## Operation
- States: IDLE, FETCH, DECODE, START, EXEC, HALT. Reset → IDLE.
- Reset values: `pc`=RESET_PC, `retired_cnt`=0, all 1-bit outputs 0, `mem_addr`=RESET_PC.
- IDLE: all outputs 0; `run`=1 → FETCH.
- FETCH: `mem_rd`=1, `mem_addr`=`pc`. `load_ir` = `mem_ready` (combinational, same cycle). `mem_ready`=1 → DECODE; else hold FETCH indefinitely.
- DECODE: `ir_opcode`=3'b111 → HALT, `pc` unchanged. Otherwise, if `exec_wait`=1: `pc`←`pc`+1 (mod 2^PC_W, wraps to 0), → START; if `exec_wait`=0, stall in DECODE.
- START: `exec_start`=1 for exactly one cycle; → EXEC unconditionally.
- EXEC: wait for `exec_wait`=1; then `retired_cnt`←`retired_cnt`+1 (holds at 16'hFFFF), next state FETCH if `run`=1, else IDLE.
- HALT: `halted`=1; sticky, only reset exits. `run` ignored.
- `mem_ready` is ignored outside FETCH. `run` sampled only in IDLE and at EXEC completion.

## Timing
- Moore outputs except `load_ir` (Mealy on `mem_ready` in FETCH).
- Minimum instruction cost with zero-wait memory: FETCH 1 + DECODE 1 + START 1 + EXEC (execute latency) cycles.
- `exec_start` high for a single cycle per instruction; EXEC ignores `exec_wait` in its first cycle (execute controller leaves its wait state on the START edge, so `exec_wait` is 0 there).
- `pc` increments on the DECODE→START edge; visible in START.
- Reset asserted mid-FETCH/EXEC: `mem_rd`, `exec_start`, `load_ir` drop in the same cycle (asynchronous); in-flight instruction abandoned, not counted.
- PC wrap: `pc`=2^PC_W−1 issuing a non-HALT → `pc`=0 next.

## Structure
- Shared package `cpu_pkg`: state encoding constants (3-bit), `OPC_HALT`=3'b111, execute-controller opcode constants already used by the decode.
- One sub-module natural: `pc_counter` (PC_W-bit register with reset value, increment enable, wrap).
- Retire counter and FSM inline in `fetch_sequencer`.

## Test plan
- Reset, `run`=0 for 5 cycles → IDLE, `pc`=0, `mem_rd`=0, `halted`=0, `retired_cnt`=0.
- `run`=1, `mem_ready` tied 1, opcode 3'b101, execute model returns `exec_wait`=1 4 cycles after start → `exec_start` one cycle per instruction, `pc` 0,1,2,3; `retired_cnt`=3 after 3 instructions.
- `mem_ready` delayed 3 cycles in FETCH → `mem_rd`=1 and `mem_addr`=`pc` held 4 cycles; `load_ir` high only on the ready cycle.
- Instruction at pc=2 has opcode 3'b111 → `halted`=1, `pc`=2, no `exec_start`; `run` toggling afterwards has no effect until reset.
- `PC_W`=4, `RESET_PC`=14, three non-HALT instructions → `pc` 14,15,0,1.
- Reset asserted in EXEC → outputs at reset values the same cycle, `retired_cnt`=0; first fetch after reset at `mem_addr`=RESET_PC.
